vpu_cmd_queue: RTL and testbench

//  Buffers CPU->VPU geometry commands so the CPU no longer stalls on the VPU's busy signal per command.

---
 rtl/vpu_pkg.sv | 37 +++
 rtl/vpu_cmd_fifo.sv | 62 ++++++
 rtl/vpu_cmd_queue.sv | 140 ++++++++++++++
 tb/tb_vpu_cmd_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// vpu_pkg: shared definitions for the CPU->VPU command queue.
//  - fixed field widths of a geometry command
//  - issue FSM state encoding
//  - helper that sizes the packed command word for a given parameter set
// Command word layout, MSB to LSB:
//  {fill, obj_type, obj_color, op, code, obj_num, v[NUM_V*V_W-1:0]}  (V0 in LSBs)
package vpu_pkg;

  localparam int unsigned OP_W       = 4;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned OBJ_TYPE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } vpu_state_e;

  function automatic int unsigned cmd_width(input int unsigned color_w,
                                            input int unsigned obj_w,
                                            input int unsigned num_v,
                                            input int unsigned v_w);
    return 1 + OBJ_TYPE_W + color_w + OP_W + CODE_W + obj_w + num_v * v_w;
  endfunction

  // Field offsets at the default geometry (NUM_V=8, V_W=16, OBJ_W=5, COLOR_W=3)
  localparam int unsigned V_LSB       = 0;
  localparam int unsigned OBJ_NUM_LSB = 8 * 16;
  localparam int unsigned CODE_LSB    = OBJ_NUM_LSB + 5;
  localparam int unsigned OP_LSB      = CODE_LSB + CODE_W;
  localparam int unsigned COLOR_LSB   = OP_LSB + OP_W;
  localparam int unsigned TYPE_LSB    = COLOR_LSB + 3;
  localparam int unsigned FILL_BIT    = TYPE_LSB + OBJ_TYPE_W;
  localparam int unsigned CMD_W       = cmd_width(3, 5, 8, 16);

endpackage

// File: rtl/vpu_cmd_fifo.sv
// vpu_cmd_fifo: synchronous DEPTH x W FIFO holding queued VPU commands.
// Ports:
//  clk, rst_n   clock, async active-low reset
//  push, push_data  write one entry (ignored when full)
//  pop          remove head entry (ignored when empty)
//  pop_data     head entry (combinational read)
//  clear        empty the FIFO (has priority over push/pop)
//  full, empty, count  occupancy status
module vpu_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 147
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  input  logic                         clear,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full && !clear;
  assign pop_ok   = pop && !empty && !clear;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vpu_cmd_queue.sv
// vpu_cmd_queue: buffers CPU geometry commands and issues them one at a
// time to matrix_top, so the CPU only stalls when the queue is full.
// Ports:
//  clk, rst_n            clock, async active-low reset
//  cpu_*                 command from CPU; cpu_start is the write strobe
//  cpu_rdy               queue can accept a command (count < DEPTH)
//  flush                 discard queued commands (in-flight one unaffected)
//  vpu_busy              matrix_top busy
//  vpu_go                1-cycle issue pulse
//  vpu_*                 in-flight command, held from issue to next issue
//  count                 queued entries, excluding the in-flight one
//  overflow              sticky: a write was dropped while full
//  idle                  queue empty and issue FSM idle
module vpu_cmd_queue
  import vpu_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NUM_V       = 8,
  parameter int unsigned V_W         = 16,
  parameter int unsigned OBJ_W       = 5,
  parameter int unsigned COLOR_W     = 3,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_start,
  input  logic                        cpu_fill,
  input  logic [1:0]                  cpu_obj_type,
  input  logic [COLOR_W-1:0]          cpu_obj_color,
  input  logic [3:0]                  cpu_op,
  input  logic [3:0]                  cpu_code,
  input  logic [OBJ_W-1:0]            cpu_obj_num,
  input  logic [NUM_V*V_W-1:0]        cpu_v,
  output logic                        cpu_rdy,
  input  logic                        flush,
  input  logic                        vpu_busy,
  output logic                        vpu_go,
  output logic                        vpu_fill,
  output logic [1:0]                  vpu_obj_type,
  output logic [COLOR_W-1:0]          vpu_obj_color,
  output logic [3:0]                  vpu_op,
  output logic [3:0]                  vpu_code,
  output logic [OBJ_W-1:0]            vpu_obj_num,
  output logic [NUM_V*V_W-1:0]        vpu_v,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        overflow,
  output logic                        idle
);

  localparam int unsigned Q_CMD_W = cmd_width(COLOR_W, OBJ_W, NUM_V, V_W);
  localparam int unsigned TMR_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  vpu_state_e         state;
  logic [TMR_W-1:0]   timer;
  logic [Q_CMD_W-1:0] wr_cmd;
  logic [Q_CMD_W-1:0] rd_cmd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign wr_cmd = {cpu_fill, cpu_obj_type, cpu_obj_color, cpu_op, cpu_code,
                   cpu_obj_num, cpu_v};

  // Flush wins over a same-cycle write and blocks issue for that cycle
  assign push    = cpu_start && !fifo_full && !flush;
  assign pop     = (state == ST_IDLE) && !fifo_empty && !flush;
  assign cpu_rdy = !fifo_full;
  assign idle    = fifo_empty && (state == ST_IDLE);

  vpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (Q_CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_cmd),
    .pop       (pop),
    .pop_data  (rd_cmd),
    .clear     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (cpu_start && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // ISSUE is the cycle vpu_go is high. A busy already seen there skips the
  // ack wait, which gives the 3-cycle minimum go spacing. Without busy the
  // command is treated as complete after ACK_TIMEOUT WAIT_ACK cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      vpu_go   <= 1'b0;
      {vpu_fill, vpu_obj_type, vpu_obj_color, vpu_op, vpu_code,
       vpu_obj_num, vpu_v} <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {vpu_fill, vpu_obj_type, vpu_obj_color, vpu_op, vpu_code,
             vpu_obj_num, vpu_v} <= rd_cmd;
            vpu_go <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          vpu_go <= 1'b0;
          timer  <= '0;
          state  <= vpu_busy ? ST_WAIT_DONE : ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (vpu_busy) begin
            state <= ST_WAIT_DONE;
          end else if (timer == TMR_LAST) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!vpu_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_cmd_queue.sv
module tb_vpu_cmd_queue;

  localparam int unsigned CW = 147;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_start = 1'b0;
  logic         cpu_fill = 1'b0;
  logic [1:0]   cpu_obj_type = '0;
  logic [2:0]   cpu_obj_color = '0;
  logic [3:0]   cpu_op = '0;
  logic [3:0]   cpu_code = '0;
  logic [4:0]   cpu_obj_num = '0;
  logic [127:0] cpu_v = '0;
  logic         cpu_rdy;
  logic         flush = 1'b0;
  logic         vpu_busy = 1'b0;
  logic         vpu_go;
  logic         vpu_fill;
  logic [1:0]   vpu_obj_type;
  logic [2:0]   vpu_obj_color;
  logic [3:0]   vpu_op;
  logic [3:0]   vpu_code;
  logic [4:0]   vpu_obj_num;
  logic [127:0] vpu_v;
  logic [3:0]   count;
  logic         overflow;
  logic         idle;

  logic [CW-1:0] dut_word;
  assign dut_word = {vpu_fill, vpu_obj_type, vpu_obj_color, vpu_op, vpu_code,
                     vpu_obj_num, vpu_v};

  vpu_cmd_queue #(
    .DEPTH(8), .NUM_V(8), .V_W(16), .OBJ_W(5), .COLOR_W(3), .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .cpu_fill(cpu_fill),
    .cpu_obj_type(cpu_obj_type), .cpu_obj_color(cpu_obj_color),
    .cpu_op(cpu_op), .cpu_code(cpu_code), .cpu_obj_num(cpu_obj_num),
    .cpu_v(cpu_v), .cpu_rdy(cpu_rdy), .flush(flush), .vpu_busy(vpu_busy),
    .vpu_go(vpu_go), .vpu_fill(vpu_fill), .vpu_obj_type(vpu_obj_type),
    .vpu_obj_color(vpu_obj_color), .vpu_op(vpu_op), .vpu_code(vpu_code),
    .vpu_obj_num(vpu_obj_num), .vpu_v(vpu_v), .count(count),
    .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_go = 0;
  int last_go_cyc = 0;
  int prev_go_cyc = 0;
  int max_cnt = 0;
  logic prev_go = 1'b0;
  logic inflight_valid = 1'b0;
  logic [CW-1:0] inflight = '0;
  logic [CW-1:0] exp_q[$];
  int resp_mode = 0;   // 0: busy driven by main, 2: pulse busy after each go
  int busy_len = 4;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int k);
    logic [7:0]   kk;
    logic [127:0] v;
    kk = 8'(k);
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = {kk, 8'(i)};
    return {kk[0], kk[2:1], kk[5:3], kk[3:0], ~kk[3:0], kk[4:0], v};
  endfunction

  task automatic drive(input logic [CW-1:0] w, input bit expect_accept);
    {cpu_fill, cpu_obj_type, cpu_obj_color, cpu_op, cpu_code, cpu_obj_num, cpu_v} = w;
    cpu_start = 1'b1;
    if (expect_accept) exp_q.push_back(w);
    @(negedge clk);
    cpu_start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    for (int i = 0; i < maxc && !idle; i++) @(negedge clk);
    chk(nm, idle, 1'b1);
  endtask

  task automatic wait_go(input int target, input int maxc, input string nm);
    for (int i = 0; i < maxc && n_go < target; i++) @(negedge clk);
    chk(nm, n_go >= target, 1'b1);
  endtask

  always @(posedge clk) cyc++;

  // Responder standing in for matrix_top
  initial begin
    forever begin
      @(negedge clk);
      if (resp_mode == 2 && vpu_go && rst_n) begin
        vpu_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        vpu_busy = 1'b0;
      end
    end
  end

  // Monitor: checks every issued command against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (rst_n) begin
        if (vpu_go) begin
          chk("go_width", prev_go, 1'b0);
          if (n_go > 0) chk("go_spacing", (cyc - last_go_cyc) >= 3, 1'b1);
          chk("go_has_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) chk("issue_cmd", dut_word, exp_q.pop_front());
          prev_go_cyc = last_go_cyc;
          last_go_cyc = cyc;
          n_go++;
          inflight = dut_word;
          inflight_valid = 1'b1;
        end else if (vpu_busy && inflight_valid) begin
          chk("hold_while_busy", dut_word, inflight);
        end
      end
      prev_go = vpu_go;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int wr_cyc;
    logic [CW-1:0] w1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_go", vpu_go, 1'b0);
    chk("rst_word", dut_word, '0);
    chk("rst_count", count, 4'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_rdy", cpu_rdy, 1'b1);
    chk("rst_idle", idle, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single command, busy 4 cycles
    resp_mode = 2; busy_len = 4;
    w1 = {1'b0, 2'd1, 3'd2, 4'd3, 4'd0, 5'd5, {112'h0, 16'h0010}};
    base = n_go;
    drive(w1, 1'b1);
    wr_cyc = cyc;
    chk("t1_go_not_yet", vpu_go, 1'b0);
    wait_go(base + 1, 10, "t1_go_seen");
    chk("t1_go_latency", last_go_cyc - wr_cyc, 1);
    @(negedge clk);
    chk("t1_go_low", vpu_go, 1'b0);
    chk("t1_op_held", vpu_op, 4'd3);
    wait_idle(20, "t1_idle");
    chk("t1_op_after", vpu_op, 4'd3);

    // 2: fill with busy held high, then overflow
    resp_mode = 0; vpu_busy = 1'b1;
    for (int k = 10; k < 18; k++) drive(mk(k), 1'b1);
    chk("t2_count7", count, 4'd7);
    chk("t2_rdy", cpu_rdy, 1'b1);
    chk("t2_no_ovf", overflow, 1'b0);
    drive(mk(18), 1'b1);
    chk("t2_count8", count, 4'd8);
    chk("t2_rdy_full", cpu_rdy, 1'b0);
    drive(mk(19), 1'b0);
    chk("t2_ovf", overflow, 1'b1);
    drive(mk(20), 1'b0);
    chk("t2_count_full", count, 4'd8);
    busy_len = 2; resp_mode = 2; vpu_busy = 1'b0;
    wait_idle(300, "t2_drain_idle");
    chk("t2_scoreboard_empty", exp_q.size(), 0);
    chk("t2_ovf_sticky", overflow, 1'b1);

    // 3: busy never rises, ack timeout
    resp_mode = 0; vpu_busy = 1'b0;
    base = n_go;
    drive(mk(30), 1'b1);
    drive(mk(31), 1'b1);
    wait_go(base + 2, 40, "t3_two_gos");
    chk("t3_go_gap", last_go_cyc - prev_go_cyc, 6);
    wait_idle(20, "t3_idle");

    // 4: flush with cpu_start during WAIT_DONE
    resp_mode = 2; busy_len = 12;
    base = n_go;
    for (int k = 40; k < 46; k++) drive(mk(k), 1'b1);
    chk("t4_count5", count, 4'd5);
    chk("t4_busy", vpu_busy, 1'b1);
    flush = 1'b1;
    exp_q.delete();
    drive(mk(46), 1'b0);
    flush = 1'b0;
    chk("t4_count0", count, 4'd0);
    chk("t4_ovf_clr", overflow, 1'b0);
    chk("t4_inflight", dut_word, mk(40));
    repeat (30) @(negedge clk);
    chk("t4_no_more_go", n_go, base + 1);
    chk("t4_idle", idle, 1'b1);

    // 5: 20 commands with mixed push/pop, pointers wrap
    resp_mode = 2; busy_len = 1;
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      for (int t = 0; t < 50 && !cpu_rdy; t++) @(negedge clk);
      chk("t5_rdy", cpu_rdy, 1'b1);
      drive(mk(50 + i), 1'b1);
      repeat (i % 3) @(negedge clk);
    end
    wait_idle(300, "t5_idle");
    chk("t5_scoreboard_empty", exp_q.size(), 0);
    chk("t5_max_count", max_cnt <= 8, 1'b1);

    // 6: reset during WAIT_DONE with 3 queued
    resp_mode = 2; busy_len = 20;
    for (int k = 70; k < 74; k++) drive(mk(k), 1'b1);
    chk("t6_count3", count, 4'd3);
    rst_n = 1'b0;
    inflight_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_go0", vpu_go, 1'b0);
    chk("t6_word0", dut_word, '0);
    chk("t6_count0", count, 4'd0);
    chk("t6_idle", idle, 1'b1);
    chk("t6_rdy", cpu_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_go;
    repeat (40) @(negedge clk);
    chk("t6_no_go", n_go, base);
    chk("t6_idle_after", idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
